// File: rtl/pipe_elastic_3.sv
// pipe_elastic_3 -- three-stage, 8-bit elastic pipeline register.
//
// Each accepted byte travels s1 -> s2 -> s3 and is presented on out_data
// from s3. A stage advances when it is valid and the stage ahead is empty or
// emptying on the same edge, so bubbles collapse while the sink stalls.
// Order is strictly FIFO; nothing is dropped or duplicated.
//
// Optional feature, macro PIPE_ELASTIC_SKID_EN:
//   defined   - a one-entry skid buffer sits ahead of s1, capacity is 4 and
//               in_ready is a register (no combinational out_ready path).
//   undefined - no skid buffer, capacity 3, in_ready combinational from
//               out_ready through the stage chain.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   producer presents in_data
//   in_ready   block accepts in_data this cycle
//   in_data    input byte
//   out_valid  out_data holds a valid byte (stage 3 valid)
//   out_ready  consumer takes out_data this cycle
//   out_data   output byte from stage 3
//   occupancy  registered count of held bytes after the last edge

module pipe_elastic_3 (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [2:0] occupancy
);

  localparam int DATA_W = 8;

  logic              vld_p1, vld_p2, vld_p3;
  logic [DATA_W-1:0] data_p1, data_p2, data_p3;
  logic              vld_p1_nxt, vld_p2_nxt, vld_p3_nxt;
  logic [2:0]        occ_q, occ_nxt;

  logic              pop;
  logic              ld_p3, ld_p2, ld_p1;
  logic              s1_free;
  logic              push;
  logic [DATA_W-1:0] src_p1;

  // Load decisions ripple back from the sink: a stage can take a byte when
  // the stage ahead is empty or is handing its byte on this same edge.
  always_comb begin
    pop     = vld_p3 && out_ready;
    ld_p3   = vld_p2 && (!vld_p3 || pop);
    ld_p2   = vld_p1 && (!vld_p2 || ld_p3);
    s1_free = !vld_p1 || ld_p2;
  end

`ifdef PIPE_ELASTIC_SKID_EN

  logic              vld_sk, vld_sk_nxt;
  logic [DATA_W-1:0] data_sk;
  logic              rdy_q;
  logic              ld_sk;

  // in_ready is registered as !vk, so a push can only happen with the skid
  // empty; a held skid byte always goes into s1 before new input is taken.
  always_comb begin
    push       = in_valid && rdy_q;
    ld_sk      = push && !s1_free;
    ld_p1      = s1_free && (vld_sk || push);
    src_p1     = vld_sk ? data_sk : in_data;
    vld_sk_nxt = vld_sk;
    if (ld_sk)
      vld_sk_nxt = 1'b1;
    else if (vld_sk && s1_free)
      vld_sk_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sk  <= 1'b0;
      data_sk <= '0;
      rdy_q   <= 1'b1;
    end else begin
      vld_sk <= vld_sk_nxt;
      rdy_q  <= !vld_sk_nxt;
      if (ld_sk)
        data_sk <= in_data;
    end
  end

  assign in_ready = rdy_q;

`else

  always_comb begin
    push   = in_valid && s1_free;
    ld_p1  = push;
    src_p1 = in_data;
  end

  assign in_ready = s1_free;

`endif

  // Next valid bits: a loading stage becomes valid, a stage that moves on
  // without being refilled is cleared, otherwise it holds.
  always_comb begin
    vld_p1_nxt = ld_p1 ? 1'b1 : (ld_p2 ? 1'b0 : vld_p1);
    vld_p2_nxt = ld_p2 ? 1'b1 : (ld_p3 ? 1'b0 : vld_p2);
    vld_p3_nxt = ld_p3 ? 1'b1 : (pop   ? 1'b0 : vld_p3);
    occ_nxt    = {2'b00, vld_p1_nxt} + {2'b00, vld_p2_nxt} + {2'b00, vld_p3_nxt};
`ifdef PIPE_ELASTIC_SKID_EN
    occ_nxt    = occ_nxt + {2'b00, vld_sk_nxt};
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      vld_p3  <= 1'b0;
      data_p1 <= '0;
      data_p2 <= '0;
      data_p3 <= '0;
      occ_q   <= '0;
    end else begin
      // stage 1 boundary
      vld_p1 <= vld_p1_nxt;
      if (ld_p1)
        data_p1 <= src_p1;
      // stage 2 boundary
      vld_p2 <= vld_p2_nxt;
      if (ld_p2)
        data_p2 <= data_p1;
      // stage 3 boundary
      vld_p3 <= vld_p3_nxt;
      if (ld_p3)
        data_p3 <= data_p2;
      occ_q <= occ_nxt;
    end
  end

  assign out_valid = vld_p3;
  assign out_data  = data_p3;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_elastic_3.sv
module tb_pipe_elastic_3;

`ifdef PIPE_ELASTIC_SKID_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [2:0] occupancy;

  pipe_elastic_3 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         pops   = 0;
  bit         mon_en = 1'b0;
  logic [7:0] q[$];
  logic [7:0] in_b;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Input side: every accepted byte is queued as the next expected output.
  initial forever begin
    @(negedge clk);
    if (mon_en && in_valid && in_ready) begin
      in_b = in_data;
      @(posedge clk);
      q.push_back(in_b);
    end
  end

  // Output side: compare against the queue model whenever the DUT presents.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      chk("occupancy", {29'd0, occupancy}, q.size());
`ifdef PIPE_ELASTIC_SKID_EN
      if (q.size() == CAP) chk("in_ready_full", {31'd0, in_ready}, 0);
`else
      chk("in_ready", {31'd0, in_ready}, {31'd0, (q.size() < 3) || out_ready});
`endif
      if (q.size() == 0)   chk("out_valid_empty", {31'd0, out_valid}, 0);
      if (q.size() == CAP) chk("out_valid_full", {31'd0, out_valid}, 1);
      if (out_valid && q.size() > 0) begin
        chk("out_data", {24'd0, out_data}, {24'd0, q[0]});
        if (out_ready) begin
          void'(q.pop_front());
          pops++;
        end
      end
    end
  end

  task automatic check_reset_outputs(string tag);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 0);
    chk({tag, "_occupancy"}, {29'd0, occupancy}, 0);
    chk({tag, "_out_data"},  {24'd0, out_data}, 0);
    chk({tag, "_in_ready"},  {31'd0, in_ready}, 1);
  endtask

  // Push an incrementing sequence with the sink stalled; leaves in_valid high
  // with the next (unaccepted) byte on in_data.
  task automatic fill(input logic [7:0] start, output int acc);
    logic took;
    acc = 0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = start;
    repeat (8) begin
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk); #1;
      if (took) begin
        acc++;
        in_data = in_data + 8'd1;
      end
    end
  endtask

  task automatic drain(string name);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (occupancy == 0) break;
    end
    chk(name, {29'd0, occupancy}, 0);
  endtask

  initial begin
    int acc;
    int p0;
    int pin, pout;

    // Reset state
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    mon_en = 1'b1;

    // Stream: 0x11, 0x22, 0x33 on consecutive edges
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h11;
    @(posedge clk); #1;
    in_data = 8'h22;
    @(posedge clk); #1;
    in_data = 8'h33;
    chk("stream_early_valid", {31'd0, out_valid}, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("stream_v0", {31'd0, out_valid}, 1);
    chk("stream_d0", {24'd0, out_data}, 32'h11);
    @(posedge clk); #1;
    chk("stream_v1", {31'd0, out_valid}, 1);
    chk("stream_d1", {24'd0, out_data}, 32'h22);
    @(posedge clk); #1;
    chk("stream_v2", {31'd0, out_valid}, 1);
    chk("stream_d2", {24'd0, out_data}, 32'h33);
    drain("stream_drain");

    // Backpressure: fills to capacity, then releases in order
    fill(8'hA0, acc);
    chk("bp_accepted", acc, CAP);
    chk("bp_in_ready", {31'd0, in_ready}, 0);
    chk("bp_occ", {29'd0, occupancy}, CAP);
    p0 = pops;
    drain("bp_drain");
    chk("bp_pops", pops - p0, CAP);

    // Full pipeline with a simultaneous pop and push attempt
    fill(8'h01, acc);
    out_ready = 1'b1;
    @(negedge clk);
`ifdef PIPE_ELASTIC_SKID_EN
    chk("full_in_ready", {31'd0, in_ready}, 0);
`else
    chk("full_in_ready", {31'd0, in_ready}, 1);
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("full_occ", {29'd0, occupancy}, 3);
    chk("full_next", {24'd0, out_data}, 32'h02);
    drain("full_drain");

    // Bubble collapse
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h55;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b1; in_data = 8'h66;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("bubble_occ", {29'd0, occupancy}, 2);
    chk("bubble_first", {24'd0, out_data}, 32'h55);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bubble_second_v", {31'd0, out_valid}, 1);
    chk("bubble_second_d", {24'd0, out_data}, 32'h66);
    @(posedge clk); #1;
    chk("bubble_empty", {31'd0, out_valid}, 0);

    // Reset mid-stream with two bytes held
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hC0;
    @(posedge clk); #1;
    in_data = 8'hC1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    q.delete();
    @(posedge clk); #3;
    rst = 1'b0;
    mon_en = 1'b1;

    // Random traffic in three load profiles
    for (int seg = 0; seg < 3; seg++) begin
      pin  = (seg == 0) ? 85 : (seg == 1) ? 50 : 30;
      pout = (seg == 0) ? 30 : (seg == 1) ? 50 : 90;
      for (int c = 0; c < 3300; c++) begin
        @(posedge clk); #1;
        in_valid  = ($urandom_range(0, 99) < pin);
        in_data   = 8'($urandom);
        out_ready = ($urandom_range(0, 99) < pout);
      end
    end
    drain("rand_drain");
    @(negedge clk);
    chk("rand_queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
